// File: rtl/tawas_pkg.sv
// Shared thread-scheduler constants and types for the tawas barrel pipeline.
package tawas_pkg;
  localparam int NUM_THREADS = 32;
  localparam int THREAD_W    = 5;
  localparam int STAGES      = 3;   // load, decode, store

  typedef logic [THREAD_W-1:0] tid_t;
endpackage

// File: rtl/tawas_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr+1, wrapping.
module tawas_rr_pick
  import tawas_pkg::*;
(
  input  logic [NUM_THREADS-1:0] req,
  input  tid_t                   ptr,
  output logic                   gnt_vld,
  output tid_t                   gnt_id
);

  logic [2*NUM_THREADS-1:0] w_rot_full;
  logic [NUM_THREADS-1:0]   w_rot;
  tid_t                     w_start;
  tid_t                     w_off;

  always_comb begin
    w_start    = ptr + 1'b1;                 // 31 wraps to 0 in THREAD_W bits
    w_rot_full = {req, req} >> w_start;
    w_rot      = w_rot_full[NUM_THREADS-1:0];
    w_off      = '0;
    for (int i = NUM_THREADS-1; i >= 0; i--)
      if (w_rot[i]) w_off = tid_t'(i);
    gnt_vld = |req;
    gnt_id  = w_start + w_off;
  end

endmodule

// File: rtl/tawas_sched.sv
// Round-robin thread scheduler feeding a 3-slot (load/decode/store) barrel pipeline.
module tawas_sched
  import tawas_pkg::*;
#(
  parameter tid_t RESET_PTR = 5'd31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_mask,
  input  logic [NUM_THREADS-1:0] rcn_stall,
  output logic                   thread_load_en,
  output logic [THREAD_W-1:0]    thread_load,
  output logic                   thread_decode_en,
  output logic [THREAD_W-1:0]    thread_decode,
  output logic                   thread_store_en,
  output logic [THREAD_W-1:0]    thread_store,
  output logic                   sched_idle
);

  logic [STAGES-1:0]               r_vld_pipe;
  logic [STAGES-1:0][THREAD_W-1:0] r_id_pipe;
  tid_t                            r_ptr;
  logic                            r_idle;

  logic [NUM_THREADS-1:0] w_busy;
  logic [NUM_THREADS-1:0] w_elig;
  logic                   w_gnt_vld;
  tid_t                   w_gnt_id;

  // Threads still in load or decode cannot re-issue; the store slot frees them.
  always_comb begin
    w_busy = '0;
    if (r_vld_pipe[0]) w_busy[r_id_pipe[0]] = 1'b1;
    if (r_vld_pipe[1]) w_busy[r_id_pipe[1]] = 1'b1;
    w_elig = thread_mask & ~rcn_stall & ~w_busy;
  end

  tawas_rr_pick u_pick (
    .req     (w_elig),
    .ptr     (r_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_id  (w_gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
      r_ptr      <= RESET_PTR;
      r_idle     <= 1'b1;
    end else begin
      r_vld_pipe              <= {r_vld_pipe[STAGES-2:0], w_gnt_vld};
      r_id_pipe[STAGES-1:1]   <= r_id_pipe[STAGES-2:0];
      if (w_gnt_vld) begin
        r_id_pipe[0] <= w_gnt_id;
        r_ptr        <= w_gnt_id;
      end
      r_idle <= ~w_gnt_vld;
    end
  end

  assign thread_load_en   = r_vld_pipe[0];
  assign thread_load      = r_id_pipe[0];
  assign thread_decode_en = r_vld_pipe[1];
  assign thread_decode    = r_id_pipe[1];
  assign thread_store_en  = r_vld_pipe[2];
  assign thread_store     = r_id_pipe[2];
  assign sched_idle       = r_idle;

endmodule

// File: tb/tb_tawas_sched.sv
// Self-checking bench for tawas_sched: directed scenarios plus randomized traffic vs a slot-list model.
module tb_tawas_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] thread_mask = '0;
  logic [31:0] rcn_stall   = '0;
  logic        load_en, decode_en, store_en, idle;
  logic [4:0]  load, decode, store;

  tawas_sched dut (
    .clk              (clk),
    .rst              (rst),
    .thread_mask      (thread_mask),
    .rcn_stall        (rcn_stall),
    .thread_load_en   (load_en),
    .thread_load      (load),
    .thread_decode_en (decode_en),
    .thread_decode    (decode),
    .thread_store_en  (store_en),
    .thread_store     (store),
    .sched_idle       (idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: list of the three most recent slots (0=load,1=decode,2=store).
  bit m_en[3];
  int m_id[3];
  int m_ptr;
  bit m_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin m_en[s] = 0; m_id[s] = 0; end
    m_ptr  = 31;
    m_idle = 1;
  endtask

  task automatic model_step(input logic [31:0] m, input logic [31:0] s);
    bit elig[32];
    int g;
    g = -1;
    for (int n = 0; n < 32; n++)
      elig[n] = m[n] && !s[n] && !(m_en[0] && m_id[0] == n) && !(m_en[1] && m_id[1] == n);
    for (int k = 1; k <= 32 && g < 0; k++)
      if (elig[(m_ptr + k) % 32]) g = (m_ptr + k) % 32;
    m_en[2] = m_en[1]; m_id[2] = m_id[1];
    m_en[1] = m_en[0]; m_id[1] = m_id[0];
    if (g >= 0) begin
      m_en[0] = 1; m_id[0] = g; m_ptr = g; m_idle = 0;
    end else begin
      m_en[0] = 0; m_idle = 1;
    end
  endtask

  task automatic check_all();
    chk("load_en",   32'(load_en),   32'(m_en[0]));
    chk("load",      32'(load),      32'(m_id[0]));
    chk("decode_en", 32'(decode_en), 32'(m_en[1]));
    chk("decode",    32'(decode),    32'(m_id[1]));
    chk("store_en",  32'(store_en),  32'(m_en[2]));
    chk("store",     32'(store),     32'(m_id[2]));
    chk("idle",      32'(idle),      32'(m_idle));
  endtask

  // Called at a negedge; applies inputs, advances one edge, checks at next negedge.
  task automatic cyc(input logic [31:0] m, input logic [31:0] s);
    thread_mask = m;
    rcn_stall   = s;
    model_step(m, s);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse starting mid-cycle; checked before any clock edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_async_load_en"}, 32'(load_en), 32'd0);
    chk({tag, "_async_idle"},    32'(idle),    32'd1);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    int exp31[3];
    logic [31:0] m, s;
    exp31[0] = 0; exp31[1] = 1; exp31[2] = 31;

    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Full mask: strict 0..31,0 sequence with no bubbles.
    for (int i = 0; i < 34; i++) begin
      cyc(32'hFFFF_FFFF, '0);
      chk("seq_all", 32'(load), 32'(i % 32));
      chk("seq_all_en", 32'(load_en), 32'd1);
    end

    // Reset with all three slots valid; first grant is thread 0.
    pulse_reset("mid");
    cyc(32'hFFFF_FFFF, '0);
    chk("post_rst_load", 32'(load), 32'd0);

    // Single thread: one grant every 3 cycles.
    pulse_reset("r1");
    for (int i = 0; i < 9; i++) begin
      cyc(32'h0000_0010, '0);
      chk("single_en", 32'(load_en), 32'(i % 3 == 0));
      if (i % 3 == 0) chk("single_id", 32'(load), 32'd4);
    end

    // Wrap-around with three threads straddling 31->0.
    pulse_reset("r2");
    for (int i = 0; i < 9; i++) begin
      cyc(32'h8000_0003, '0);
      chk("wrap_id", 32'(load), 32'(exp31[i % 3]));
    end

    // Stall thread 3 for 10 cycles in an 8-thread mix.
    pulse_reset("r3");
    for (int i = 0; i < 6; i++) cyc(32'h0000_00FF, '0);
    for (int i = 0; i < 10; i++) begin
      cyc(32'h0000_00FF, 32'h0000_0008);
      chk("stall_absent", 32'(load_en && load == 5'd3), 32'd0);
    end
    for (int i = 0; i < 10; i++) cyc(32'h0000_00FF, '0);

    // Empty mask stays idle; new mask bit granted at the next edge.
    pulse_reset("r4");
    for (int i = 0; i < 5; i++) begin
      cyc('0, '0);
      chk("empty_idle", 32'(idle), 32'd1);
    end
    cyc(32'h0000_0400, '0);
    chk("wake_id", 32'(load), 32'd10);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: m = $urandom();
        1: m = $urandom() & $urandom() & $urandom();
        2: m = 32'(1) << $urandom_range(0, 31);
        default: m = $urandom() | $urandom();
      endcase
      s = ($urandom_range(0, 1) == 0) ? '0 : ($urandom() & $urandom());
      cyc(m, s);
      if ($urandom_range(0, 79) == 0) pulse_reset("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
